// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter_pkg
// Purpose : Shared constants and types for the register-file write-port
//           arbiter and its M-result FIFO.
// Contents: RF_XLEN / RF_AW default widths, write-request struct,
//           write-port selection-source enum.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_AW   = 5;

  // One register-file write: destination index plus data.
  typedef struct packed {
    logic [RF_AW-1:0]   rd;
    logic [RF_XLEN-1:0] data;
  } wr_req_t;

  // Which requester owns the write port in the coming cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_P    = 2'd1,
    SEL_FIFO = 2'd2,
    SEL_M    = 2'd3
  } sel_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter_wb_fifo
// Purpose : DEPTH-entry synchronous FIFO holding M write requests until the
//           register-file write port is free. Exposes per-entry valid bits
//           and rd fields so the arbiter can do pending/conflict compares.
// Ports   : clk, rst (async active-low)
//           push, push_rd, push_data   - enqueue at tail
//           pop                        - dequeue head
//           head_rd, head_data         - oldest entry
//           count                      - occupancy 0..DEPTH
//           entry_valid[DEPTH]         - slot holds a live entry
//           entry_rd[DEPTH*AW]         - rd of each slot (slot i at i*AW)
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [AW-1:0]     push_rd,
  input  logic [XLEN-1:0]   push_data,
  input  logic              pop,
  output logic [AW-1:0]     head_rd,
  output logic [XLEN-1:0]   head_data,
  output logic [CW-1:0]     count,
  output logic [DEPTH-1:0]  entry_valid,
  output logic [DEPTH*AW-1:0] entry_rd
);

  logic [AW-1:0]   rd_q   [DEPTH];
  logic [AW-1:0]   rd_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // DEPTH is a power of two, so the pointers wrap naturally at DEPTH.
  always_comb begin
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      rd_d[wr_ptr_q]   = push_rd;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_q     <= rd_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_rd   = rd_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign count     = count_q;

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] offs;
    assign offs                  = PW'(i) - rd_ptr_q;
    assign entry_valid[i]        = (CW'(offs) < count_q);
    assign entry_rd[i*AW +: AW]  = rd_q[i];
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_arbiter
// Purpose : Shares the register-file write port between the pipeline
//           writeback stage (P, priority) and a long-latency unit (M, via
//           valid/ready into a small FIFO). Flags decode operands that still
//           have a write in flight.
// Ports   : clk, rst (async active-low)
//           p_valid/p_rd/p_data, p_stall        - pipeline writeback
//           m_valid/m_ready/m_rd/m_data         - M result handshake
//           readregA/B -> pendA/B               - pending-write flags
//           RegWrite/writereg/writedata         - registered write port
//           fifo_count                          - M FIFO occupancy
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = RF_XLEN,
  parameter int AW           = RF_AW,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CW          = $clog2(DEPTH) + 1,
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_valid,
  input  logic [AW-1:0]   p_rd,
  input  logic [XLEN-1:0] p_data,
  output logic            p_stall,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [AW-1:0]   m_rd,
  input  logic [XLEN-1:0] m_data,
  input  logic [AW-1:0]   readregA,
  input  logic [AW-1:0]   readregB,
  output logic            pendA,
  output logic            pendB,
  output logic            RegWrite,
  output logic [AW-1:0]   writereg,
  output logic [XLEN-1:0] writedata,
  output logic [CW-1:0]   fifo_count
);

  logic [CW-1:0]       count;
  logic [DEPTH-1:0]    entry_valid;
  logic [DEPTH*AW-1:0] entry_rd;
  logic [AW-1:0]       head_rd;
  logic [XLEN-1:0]     head_data;

  logic                reg_write_q, reg_write_d;
  logic [AW-1:0]       writereg_q,  writereg_d;
  logic [XLEN-1:0]     writedata_q, writedata_d;
  logic [SW-1:0]       starve_q,    starve_d;

  logic fifo_ne, mh, m_req, p_req, p_hit, hit_a, hit_b, conflict, push, pop;
  sel_e sel;

  regfile_wb_arbiter_wb_fifo #(
    .XLEN  (XLEN),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_rd     (m_rd),
    .push_data   (m_data),
    .pop         (pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Occupancy-only ready: a full FIFO never accepts, even if it dequeues.
  assign m_ready = rst & (count < CW'(DEPTH));
  assign fifo_ne = (count != '0);
  assign mh      = m_valid & m_ready;
  assign m_req   = mh & (m_rd != '0);
  assign p_req   = p_valid & (p_rd != '0);

  always_comb begin
    p_hit = 1'b0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_rd[i*AW +: AW] == p_rd)     p_hit = 1'b1;
      if (entry_valid[i] && entry_rd[i*AW +: AW] == readregA) hit_a = 1'b1;
      if (entry_valid[i] && entry_rd[i*AW +: AW] == readregB) hit_b = 1'b1;
    end
  end

  // P must not overtake an older M write to the same register.
  assign conflict = p_req & (p_hit | (m_req & (m_rd == p_rd)));

  always_comb begin
    sel     = SEL_NONE;
    p_stall = 1'b0;
    if (fifo_ne && (starve_q == SW'(STARVE_LIMIT) || conflict)) begin
      sel     = SEL_FIFO;
      p_stall = 1'b1;
    end else if (conflict) begin
      // FIFO empty: the conflicting M result bypasses first, P retries.
      sel     = SEL_M;
      p_stall = 1'b1;
    end else if (p_req) begin
      sel = SEL_P;
    end else if (fifo_ne) begin
      sel = SEL_FIFO;
    end else if (m_req) begin
      sel = SEL_M;
    end
  end

  assign pop  = (sel == SEL_FIFO);
  assign push = m_req & (sel != SEL_M);

  always_comb begin
    reg_write_d = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    case (sel)
      SEL_P: begin
        reg_write_d = 1'b1;
        writereg_d  = p_rd;
        writedata_d = p_data;
      end
      SEL_FIFO: begin
        reg_write_d = 1'b1;
        writereg_d  = head_rd;
        writedata_d = head_data;
      end
      SEL_M: begin
        reg_write_d = 1'b1;
        writereg_d  = m_rd;
        writedata_d = m_data;
      end
      default: ;
    endcase

    starve_d = starve_q;
    if (!fifo_ne || pop) begin
      starve_d = '0;
    end else if (sel == SEL_P && starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      starve_q    <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      starve_q    <= starve_d;
    end
  end

  assign RegWrite   = reg_write_q;
  assign writereg   = writereg_q;
  assign writedata  = writedata_q;
  assign fifo_count = count;

  assign pendA = (readregA != '0) & (hit_a | (reg_write_q & (writereg_q == readregA)));
  assign pendB = (readregB != '0) & (hit_b | (reg_write_q & (writereg_q == readregB)));

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Purpose : Self-checking bench for regfile_wb_arbiter. Directed scenarios
//           followed by random traffic, all checked against a queue-based
//           reference model of the arbitration rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid, m_valid;
  logic [4:0]  p_rd, m_rd, readregA, readregB;
  logic [31:0] p_data, m_data;
  logic        p_stall, m_ready, pendA, pendB, RegWrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [1:0]  fifo_count;

  regfile_wb_arbiter #(
    .XLEN(32), .AW(5), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_stall(p_stall),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .readregA(readregA), .readregB(readregB), .pendA(pendA), .pendB(pendB),
    .RegWrite(RegWrite), .writereg(writereg), .writedata(writedata),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        q[$];
  int          starve;
  logic        e_we;
  logic [4:0]  e_wr;
  logic [31:0] e_wd;

  int vectors = 0;
  int checks  = 0;
  int fails   = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(logic [4:0] r);
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pend_of(logic [4:0] r);
    return (r != 0) && (in_q(r) || (e_we && e_wr == r));
  endfunction

  task automatic drive(bit pv, logic [4:0] prd, logic [31:0] pd,
                       bit mv, logic [4:0] mrd, logic [31:0] md,
                       logic [4:0] ra, logic [4:0] rb);
    p_valid = pv; p_rd = prd; p_data = pd;
    m_valid = mv; m_rd = mrd; m_data = md;
    readregA = ra; readregB = rb;
  endtask

  function automatic void model_reset();
    q.delete();
    starve = 0;
    e_we = 1'b0; e_wr = '0; e_wd = '0;
  endfunction

  // One clock: check combinational outputs against the model, let the edge
  // happen, advance the model, check the registered write port.
  task automatic step();
    int   sz, sel;
    bit   mr, mreq, preq, conf, stall;
    ent_t h;
    #1;
    sz    = q.size();
    mr    = (sz < DEPTH);
    mreq  = m_valid && mr && (m_rd != 0);
    preq  = p_valid && (p_rd != 0);
    conf  = preq && (in_q(p_rd) || (mreq && m_rd == p_rd));
    stall = 1'b0;
    if (sz > 0 && (starve == LIMIT || conf)) begin sel = 2; stall = 1'b1; end
    else if (conf)  begin sel = 3; stall = 1'b1; end
    else if (preq)  sel = 1;
    else if (sz > 0) sel = 2;
    else if (mreq)  sel = 3;
    else            sel = 0;
    check("m_ready",    m_ready,    mr);
    check("p_stall",    p_stall,    stall);
    check("pendA",      pendA,      pend_of(readregA));
    check("pendB",      pendB,      pend_of(readregB));
    check("fifo_count", fifo_count, sz);
    @(posedge clk);
    case (sel)
      1: begin e_we = 1'b1; e_wr = p_rd; e_wd = p_data; end
      2: begin h = q.pop_front(); e_we = 1'b1; e_wr = h.rd; e_wd = h.data; end
      3: begin e_we = 1'b1; e_wr = m_rd; e_wd = m_data; end
      default: e_we = 1'b0;
    endcase
    if (mreq && sel != 3) q.push_back('{rd: m_rd, data: m_data});
    if (sz == 0 || sel == 2) starve = 0;
    else if (sel == 1 && starve < LIMIT) starve++;
    #1;
    check("RegWrite", RegWrite, e_we);
    if (e_we) begin
      check("writereg",  writereg,  e_wr);
      check("writedata", writedata, e_wd);
    end
    check("fifo_count_post", fifo_count, q.size());
    vectors++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_RegWrite",  RegWrite,   0);
    check("rst_writereg",  writereg,   0);
    check("rst_writedata", writedata,  0);
    check("rst_count",     fifo_count, 0);
    check("rst_m_ready",   m_ready,    0);
    check("rst_p_stall",   p_stall,    0);
    @(negedge clk);
    rst = 1'b1;

    // Plain P write, then idle.
    drive(1, 5, 32'hAA, 0, 0, 0, 0, 0); step();
    check("p_wr_rd", writereg, 5);
    check("p_wr_data", writedata, 32'hAA);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("p_wr_gone", RegWrite, 0);

    // M bypass with an empty FIFO.
    drive(0, 0, 0, 1, 7, 32'h1234, 7, 0); step();
    check("m_byp_rd", writereg, 7);
    check("m_byp_cnt", fifo_count, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Starvation: P busy, two M results queued behind it.
    for (int i = 0; i < 14; i++) begin
      drive(1, 10, 32'h100 + i, (i < 2), (i == 0) ? 5'd3 : 5'd4,
            32'h300 + i, 3, 4);
      step();
      if (i == 5)  check("starve_rd3", writereg, 3);
      if (i == 10) check("starve_rd4", writereg, 4);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();

    // WAW conflict: FIFO holds rd 9, P then targets rd 9.
    drive(1, 10, 32'h1, 1, 9, 32'h99, 9, 0); step();
    drive(1, 9, 32'h55, 0, 0, 0, 9, 0); step();
    check("waw_m_first", writereg, 9);
    check("waw_m_data", writedata, 32'h99);
    drive(1, 9, 32'h55, 0, 0, 0, 9, 0); step();
    check("waw_p_next", writedata, 32'h55);
    drive(0, 0, 0, 0, 0, 0, 9, 0); step();

    // Both requesters target r0.
    drive(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0); step();
    check("r0_none", RegWrite, 0);

    // Fill the FIFO, then reset mid-cycle.
    drive(1, 10, 32'h2, 1, 11, 32'hB1, 11, 12); step();
    drive(1, 10, 32'h3, 1, 12, 32'hB2, 11, 12); step();
    check("full_count", fifo_count, 2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("mid_rst_RegWrite", RegWrite,   0);
    check("mid_rst_count",    fifo_count, 0);
    check("mid_rst_m_ready",  m_ready,    0);
    check("mid_rst_p_stall",  p_stall,    0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 11, 12);
    for (int i = 0; i < 6; i++) step();

    // Random traffic with a small register range to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters: the in-order pipeline writeback stage (P) and a long-latency unit such as a divider or load miss (M).
- P has priority. M results are accepted through a valid/ready handshake and held in a small FIFO until the port is free.
- Also flags register-file read operands that still have a write pending, so the hazard unit can stall.
- Outputs drive the register file write port directly. They are registered on the rising edge of clk, so they are stable before the register file samples them on the falling edge.

Parameters:
- XLEN, 32, data width.
- AW, 5, register index width.
- DEPTH, 2, M FIFO entries (power of two, 2..8).
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may be blocked by P before it is forced through.

Ports:
- clk  in  1  clock, rising-edge state.
- rst  in  1  asynchronous, active-low reset.
- p_valid  in  1  pipeline writeback request.
- p_rd  in  AW  pipeline destination register.
- p_data  in  XLEN  pipeline result.
- p_stall  out  1  combinational; P request not taken this cycle, pipeline must hold it.
- m_valid  in  1  M result valid.
- m_ready  out  1  arbiter can accept an M result.
- m_rd  in  AW  M destination register.
- m_data  in  XLEN  M result.
- readregA  in  AW  operand A index under decode.
- readregB  in  AW  operand B index under decode.
- pendA  out  1  write pending to readregA.
- pendB  out  1  write pending to readregB.
- RegWrite  out  1  register file write enable.
- writereg  out  AW  register file write index.
- writedata  out  XLEN  register file write data.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - RegWrite=0, writereg=0, writedata=0.
  - FIFO empty, fifo_count=0, starve counter=0.
  - m_ready=0 and p_stall=0 while rst=0.
- Handshake and request qualification:
  - m_ready = rst & (fifo_count<DEPTH). It depends only on occupancy, so there is no dequeue-enqueue pass-through when full.
  - M handshake (mh) = m_valid & m_ready.
  - p_valid with p_rd=0 is treated as no request.
  - mh with m_rd=0 is accepted and discarded; nothing is enqueued.
- Conflict: p_valid & p_rd≠0 & p_rd equals the rd of any valid FIFO entry, or equals m_rd when mh & m_rd≠0.
- Port selection, evaluated each cycle in this priority order:
  1. Force: FIFO non-empty and (starve counter=STARVE_LIMIT or conflict). Issue the FIFO head and set p_stall=1.
  2. P request present. Issue P.
  3. FIFO non-empty. Issue the head.
  4. FIFO empty and mh & m_rd≠0. Issue M directly (bypass, latency 1), no enqueue.
  5. Otherwise RegWrite=0 next cycle.
- Conflict with an empty FIFO and a valid mh: M is issued directly, p_stall=1, and P goes the next cycle.
- Any mh & m_rd≠0 not issued directly is enqueued at the tail in the same cycle as a head dequeue.
- Issue timing: the issued write appears on RegWrite/writereg/writedata at the next rising edge and is held for exactly one cycle.
- Starve counter:
  - Increments when the FIFO is non-empty and P wins.
  - Clears on any FIFO dequeue or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Pending flags:
  - pendX=1 when readregX≠0 and readregX matches a valid FIFO entry, or matches writereg while RegWrite=1.
  - Combinational.
- Ordering: FIFO entries drain in acceptance order. WAW ordering with P is guaranteed by the conflict rule.
- A FIFO pointer wrap at DEPTH must preserve order.
- Mid-operation reset drops all buffered writes.

Decomposition:
- Shared package:
  - XLEN and AW constants.
  - Write-request struct {rd, data}.
  - Selection-source enum {SEL_NONE, SEL_P, SEL_FIFO, SEL_M}.
- One sub-module: wb_fifo (DEPTH-entry synchronous FIFO with count, an exposed entry-valid vector, and rd fields for pending and conflict compare).

Test Plan:
- Reset, then p_valid, p_rd=5, p_data=0xAA -> next cycle RegWrite=1, writereg=5, writedata=0xAA, then RegWrite=0.
- FIFO empty, no P; M rd=7, data=0x1234 -> mh, next cycle writereg=7, fifo_count stays 0.
- P busy every cycle, M rd=3 then rd=4 -> fifo_count=2, m_ready=0. After STARVE_LIMIT=4 blocked cycles p_stall=1 and rd=3 is issued, then rd=4 issued after a further 4 blocked cycles.
- FIFO holds rd=9; P rd=9 -> p_stall=1, rd=9 (M data) written first, P rd=9 written next cycle. pendA=1 for readregA=9 until the final write.
- p_rd=0 and m_rd=0 simultaneously -> no RegWrite, fifo_count=0, p_stall=0.
- FIFO full (2 entries), assert rst=0 mid-cycle -> RegWrite=0, fifo_count=0, m_ready=0 immediately. After release m_ready=1, buffered writes never appear.
